// File: rtl/mult_arb_pkg.sv
// Shared constants for the two-requester multiplier share arbiter:
// FSM state encoding and default operand width / watchdog limit.
package mult_arb_pkg;

    localparam int WIDTH_DEF   = 8;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick; on a tie the side not granted last wins.
// Zero latency; no backpressure of its own, the caller decides when to sample.
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_idx
);

    assign gnt_valid = req0 | req1;
    assign gnt_idx   = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one signed multiplier between two requesters: IDLE->LAUNCH->WAIT->DELIVER, 3 cycles over
// multiplier latency; requests wait while busy. MULT_ARB_TIMEOUT_EN adds a WAIT watchdog (err=1).
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int WIDTH          = WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        req0,
    input  logic                        req1,
    input  logic signed [WIDTH-1:0]     x0,
    input  logic signed [WIDTH-1:0]     y0,
    input  logic signed [WIDTH-1:0]     x1,
    input  logic signed [WIDTH-1:0]     y1,
    output logic                        ack0,
    output logic                        ack1,
    output logic                        res_valid0,
    output logic                        res_valid1,
    output logic signed [2*WIDTH-1:0]   result,
    output logic                        err,
    output logic                        mul_start,
    output logic signed [WIDTH-1:0]     mul_x,
    output logic signed [WIDTH-1:0]     mul_y,
    input  logic                        mul_done,
    input  logic signed [2*WIDTH-1:0]   mul_result
);

`ifdef MULT_ARB_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    arb_state_e                 state_q, state_d;
    logic                       owner_q, owner_d;
    logic                       last_grant_q, last_grant_d;
    logic [1:0]                 ack_q, ack_d;
    logic [1:0]                 valid_q, valid_d;
    logic                       start_q, start_d;
    logic                       err_q, err_d;
    logic                       done_q;
    logic signed [WIDTH-1:0]    mul_x_q, mul_x_d, mul_y_q, mul_y_d;
    logic signed [2*WIDTH-1:0]  result_q, result_d;
    logic [CNT_W-1:0]           wait_cnt_q, wait_cnt_d;

    logic gnt_valid, gnt_idx, done_rise, timeout_hit;

    rr_arbiter2 u_rr (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_idx    (gnt_idx)
    );

    // A DONE level left over from the previous operation must not complete this one.
    assign done_rise   = mul_done & ~done_q;
    assign timeout_hit = TimeoutEn && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        mul_x_d      = mul_x_q;
        mul_y_d      = mul_y_q;
        result_d     = result_q;
        err_d        = err_q;
        wait_cnt_d   = wait_cnt_q;
        ack_d        = 2'b00;
        valid_d      = 2'b00;
        start_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    owner_d    = gnt_idx;
                    mul_x_d    = gnt_idx ? x1 : x0;
                    mul_y_d    = gnt_idx ? y1 : y0;
                    ack_d      = gnt_idx ? 2'b10 : 2'b01;
                    start_d    = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (done_rise) begin
                    result_d = mul_result;
                    err_d    = 1'b0;
                    valid_d  = owner_q ? 2'b10 : 2'b01;
                    state_d  = ST_DELIVER;
                end else if (timeout_hit) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    valid_d  = owner_q ? 2'b10 : 2'b01;
                    state_d  = ST_DELIVER;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_DELIVER: begin
                last_grant_d = owner_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            ack_q        <= 2'b00;
            valid_q      <= 2'b00;
            start_q      <= 1'b0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            mul_x_q      <= '0;
            mul_y_q      <= '0;
            result_q     <= '0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            ack_q        <= ack_d;
            valid_q      <= valid_d;
            start_q      <= start_d;
            err_q        <= err_d;
            done_q       <= mul_done;
            mul_x_q      <= mul_x_d;
            mul_y_q      <= mul_y_d;
            result_q     <= result_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign ack0       = ack_q[0];
    assign ack1       = ack_q[1];
    assign res_valid0 = valid_q[0];
    assign res_valid1 = valid_q[1];
    assign mul_start  = start_q;
    assign mul_x      = mul_x_q;
    assign mul_y      = mul_y_q;
    assign result     = result_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural multiplier (configurable latency,
// late DONE drop, never-done). Define MULT_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_mult_share_arbiter;

    logic               CLK = 1'b0;
    logic               RESET = 1'b1;
    logic               req0 = 1'b0, req1 = 1'b0;
    logic signed [7:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic               ack0, ack1, res_valid0, res_valid1, err, mul_start;
    logic signed [15:0] result;
    logic signed [7:0]  mul_x, mul_y;
    logic               mul_done = 1'b0;
    logic signed [15:0] mul_result = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ack1   = 0;
    int n_rv0    = 0;
    int n_rv1    = 0;

    // multiplier model controls
    int mul_lat    = 3;
    bit stale_late = 1'b0;
    bit never_done = 1'b0;
    logic               mdl_busy = 1'b0;
    int                 mdl_cnt  = 0;
    logic signed [15:0] mdl_prod = '0;

    always #5 CLK = ~CLK;

    mult_share_arbiter #(.WIDTH(8), .TIMEOUT_CYCLES(8)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .req0       (req0),
        .req1       (req1),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .ack0       (ack0),
        .ack1       (ack1),
        .res_valid0 (res_valid0),
        .res_valid1 (res_valid1),
        .result     (result),
        .err        (err),
        .mul_start  (mul_start),
        .mul_x      (mul_x),
        .mul_y      (mul_y),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    // DONE stays high after completion until the next start (or later, when stale_late is set).
    always @(posedge CLK) begin
        if (RESET) begin
            mdl_busy <= 1'b0;
            mdl_cnt  <= 0;
            mul_done <= 1'b0;
        end else if (mul_start) begin
            mdl_busy <= 1'b1;
            mdl_cnt  <= 0;
            mdl_prod <= $signed({{8{mul_x[7]}}, mul_x}) * $signed({{8{mul_y[7]}}, mul_y});
            if (!stale_late) mul_done <= 1'b0;
        end else if (mdl_busy) begin
            mdl_cnt <= mdl_cnt + 1;
            if (mdl_cnt == 1) mul_done <= 1'b0;
            if (mdl_cnt == mul_lat - 1 && !never_done) begin
                mul_done   <= 1'b1;
                mul_result <= mdl_prod;
                mdl_busy   <= 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (ack1)       n_ack1++;
        if (res_valid0) n_rv0++;
        if (res_valid1) n_rv1++;
    end

    task automatic do_reset();
        RESET = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    // cycles = negedges until an ack is seen, -1 if the bound expires
    task automatic wait_ack(output int cycles, output int idx);
        cycles = -1;
        idx    = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (ack0 || ack1) begin
                cycles = i;
                idx    = ack1 ? 1 : 0;
                return;
            end
        end
    endtask

    task automatic wait_valid(output int cycles, output int idx);
        cycles = -1;
        idx    = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge CLK);
            if (res_valid0 || res_valid1) begin
                cycles = i;
                idx    = res_valid1 ? 1 : 0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({ack0, ack1, res_valid0, res_valid1, mul_start, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 000000", {ack0, ack1, res_valid0, res_valid1, mul_start, err});
        end
        n_checks++;
        if ({result, mul_x, mul_y} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 00000000", {result, mul_x, mul_y});
        end
    endtask

    task automatic test_single();
        int cyc, idx, a1, v1;
        do_reset();
        mul_lat = 3;
        a1 = n_ack1;
        v1 = n_rv1;
        x0 = -8'sd3;
        y0 = -8'sd2;
        req0 = 1'b1;
        wait_ack(cyc, idx);
        req0 = 1'b0;
        n_checks++;
        if (cyc !== 1 || idx !== 0) begin
            n_fail++;
            $display("FAIL single_ack: got cycles=%0d idx=%0d required cycles=1 idx=0", cyc, idx);
        end
        n_checks++;
        if ({mul_start, mul_x, mul_y} !== {1'b1, 8'hFD, 8'hFE}) begin
            n_fail++;
            $display("FAIL single_launch: got start=%b x=%h y=%h required 1 fd fe", mul_start, mul_x, mul_y);
        end
        @(negedge CLK);
        n_checks++;
        if ({ack0, mul_start} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_pulse: got ack0=%b start=%b required 0 0", ack0, mul_start);
        end
        wait_valid(cyc, idx);
        n_checks++;
        if (cyc !== 4 || idx !== 0) begin
            n_fail++;
            $display("FAIL single_valid: got cycles=%0d idx=%0d required cycles=4 idx=0", cyc, idx);
        end
        n_checks++;
        if (result !== 16'h0006 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result: got %h err=%b required 0006 err=0", result, err);
        end
        @(negedge CLK);
        n_checks++;
        if (res_valid0 !== 1'b0 || result !== 16'h0006) begin
            n_fail++;
            $display("FAIL single_hold: got valid=%b result=%h required 0 0006", res_valid0, result);
        end
        n_checks++;
        if (n_ack1 !== a1 || n_rv1 !== v1) begin
            n_fail++;
            $display("FAIL single_side1: got ack1=%0d rv1=%0d pulses required 0", n_ack1 - a1, n_rv1 - v1);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, idx;
        do_reset();
        x0 = 8'sd5;
        y0 = 8'sd7;
        x1 = -8'sd4;
        y1 = 8'sd3;
        req0 = 1'b1;
        req1 = 1'b1;
        wait_ack(cyc, idx);
        req0 = 1'b0;
        n_checks++;
        if (cyc !== 1 || idx !== 0 || ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: got cycles=%0d idx=%0d ack1=%b required 1 0 0", cyc, idx, ack1);
        end
        wait_valid(cyc, idx);
        n_checks++;
        if (cyc !== 5 || idx !== 0 || result !== 16'h0023) begin
            n_fail++;
            $display("FAIL b2b_res0: got cycles=%0d idx=%0d result=%h required 5 0 0023", cyc, idx, result);
        end
        @(negedge CLK);
        n_checks++;
        if (ack1 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: got ack1=%b during DELIVER required 0", ack1);
        end
        @(negedge CLK);
        n_checks++;
        if (ack1 !== 1'b1 || mul_x !== 8'hFC || mul_y !== 8'h03) begin
            n_fail++;
            $display("FAIL b2b_second: got ack1=%b x=%h y=%h required 1 fc 03", ack1, mul_x, mul_y);
        end
        req1 = 1'b0;
        wait_valid(cyc, idx);
        n_checks++;
        if (cyc !== 5 || idx !== 1 || result !== 16'hFFF4) begin
            n_fail++;
            $display("FAIL b2b_res1: got cycles=%0d idx=%0d result=%h required 5 1 fff4", cyc, idx, result);
        end
    endtask

    task automatic test_fairness();
        int cyc, idx;
        logic [15:0] exp_res;
        do_reset();
        x0 = 8'sd2;
        y0 = 8'sd3;
        x1 = -8'sd1;
        y1 = 8'sd5;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_res = (i % 2 == 1) ? 16'hFFFB : 16'h0006;
            wait_ack(cyc, idx);
            if (i == 5) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            n_checks++;
            if (idx !== (i % 2)) begin
                n_fail++;
                $display("FAIL fair_grant%0d: got idx=%0d required %0d", i, idx, i % 2);
            end
            wait_valid(cyc, idx);
            n_checks++;
            if (idx !== (i % 2) || result !== exp_res) begin
                n_fail++;
                $display("FAIL fair_result%0d: got idx=%0d result=%h required %0d %h", i, idx, result, i % 2, exp_res);
            end
        end
    endtask

    task automatic test_stale_done();
        int cyc, idx;
        mul_lat    = 6;
        stale_late = 1'b1;
        x0 = 8'sd10;
        y0 = -8'sd10;
        @(negedge CLK);
        req0 = 1'b1;
        wait_ack(cyc, idx);
        req0 = 1'b0;
        wait_valid(cyc, idx);
        n_checks++;
        if (cyc !== 8 || idx !== 0) begin
            n_fail++;
            $display("FAIL stale_timing: got cycles=%0d idx=%0d required 8 0", cyc, idx);
        end
        n_checks++;
        if (result !== 16'hFF9C) begin
            n_fail++;
            $display("FAIL stale_result: got %h required ff9c", result);
        end
        stale_late = 1'b0;
        mul_lat    = 3;
    endtask

    task automatic test_reset_in_wait();
        int cyc, idx, v0;
        mul_lat = 20;
        x0 = 8'sd9;
        y0 = 8'sd9;
        @(negedge CLK);
        req0 = 1'b1;
        wait_ack(cyc, idx);
        req0 = 1'b0;
        repeat (3) @(negedge CLK);
        v0 = n_rv0;
        RESET = 1'b1;
        @(negedge CLK);
        n_checks++;
        if ({ack0, ack1, res_valid0, res_valid1, mul_start, err, result, mul_x, mul_y} !== 38'h0) begin
            n_fail++;
            $display("FAIL wait_reset_out: got ctl=%b result=%h x=%h y=%h required all zero",
                     {ack0, ack1, res_valid0, res_valid1, mul_start, err}, result, mul_x, mul_y);
        end
        RESET = 1'b0;
        repeat (30) @(negedge CLK);
        n_checks++;
        if (n_rv0 !== v0) begin
            n_fail++;
            $display("FAIL wait_reset_novalid: got %0d valid pulses required 0", n_rv0 - v0);
        end
        mul_lat = 3;
        x1 = -8'sd128;
        y1 = -8'sd128;
        req1 = 1'b1;
        wait_ack(cyc, idx);
        req1 = 1'b0;
        n_checks++;
        if (cyc !== 1 || idx !== 1) begin
            n_fail++;
            $display("FAIL wait_reset_idle: got cycles=%0d idx=%0d required 1 1", cyc, idx);
        end
        wait_valid(cyc, idx);
        n_checks++;
        if (idx !== 1 || result !== 16'h4000) begin
            n_fail++;
            $display("FAIL min_times_min: got idx=%0d result=%h required 1 4000", idx, result);
        end
    endtask

`ifdef MULT_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int cyc, idx;
        do_reset();
        never_done = 1'b1;
        x0 = 8'sd1;
        y0 = 8'sd1;
        req0 = 1'b1;
        wait_ack(cyc, idx);
        req0 = 1'b0;
        wait_valid(cyc, idx);
        n_checks++;
        if (cyc !== 9 || idx !== 0 || err !== 1'b1 || result !== 16'h0000) begin
            n_fail++;
            $display("FAIL timeout_abort: got cycles=%0d idx=%0d err=%b result=%h required 9 0 1 0000",
                     cyc, idx, err, result);
        end
        never_done = 1'b0;
        x0 = 8'sd7;
        y0 = -8'sd1;
        @(negedge CLK);
        req0 = 1'b1;
        wait_ack(cyc, idx);
        req0 = 1'b0;
        wait_valid(cyc, idx);
        n_checks++;
        if (err !== 1'b0 || result !== 16'hFFF9) begin
            n_fail++;
            $display("FAIL timeout_recover: got err=%b result=%h required 0 fff9", err, result);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fairness();
        test_stale_done();
        test_reset_in_wait();
`ifdef MULT_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
